// File: rtl/balance_seq.sv
// Self-balancing platform sequencer: rider detection, soft start, halt, PID vld.
// Define FAST_SIM_EN to shorten the debounce limit to 256 cycles.
module balance_seq #(
  parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
  parameter logic [12:0] WT_HYST      = 13'h0040,
  parameter logic [23:0] DB_CYC       = 24'd5_000_000,
  parameter logic [3:0]  DECIM        = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_req,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        nxt_smpl,
  input  logic [7:0]  ss_tmr,
  output logic        pwr_up,
  output logic        rider_off,
  output logic        vld,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_RIDER = 3'd1,
    SOFT_START = 3'd2,
    RUN        = 3'd3,
    HALT       = 3'd4
  } state_t;

`ifdef FAST_SIM_EN
  localparam logic [23:0] DB_LIM = 24'd256;
`else
  localparam logic [23:0] DB_LIM = DB_CYC;
`endif

  localparam logic [12:0] LO_THR = MIN_RIDER_WT - WT_HYST;

  state_t      cur;
  state_t      nxt;
  logic [23:0] db_cnt;
  logic [3:0]  smp_cnt;
  logic [12:0] sum;
  logic        cond;
  logic        db_hit;
  logic        act;
  logic        nxt_act;

  assign sum     = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign db_hit  = db_cnt >= (DB_LIM - 24'd1);
  assign act     = (cur == SOFT_START) || (cur == RUN);
  assign nxt_act = (nxt == SOFT_START) || (nxt == RUN);
  assign state   = cur;

  always_comb begin
    nxt  = cur;
    cond = 1'b0;
    case (cur)
      IDLE: nxt = WAIT_RIDER;
      WAIT_RIDER: begin
        cond = sum >= MIN_RIDER_WT;
        if (cond && db_hit) nxt = SOFT_START;
      end
      SOFT_START, RUN: begin
        cond = sum < LO_THR;
        // Rider loss wins over soft-start completion.
        if (cond && db_hit)
          nxt = HALT;
        else if (cur == SOFT_START && ss_tmr == 8'hFF)
          nxt = RUN;
      end
      HALT:    nxt = WAIT_RIDER;
      default: nxt = IDLE;
    endcase
    if (!en_req) nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= IDLE;
      db_cnt    <= '0;
      smp_cnt   <= '0;
      pwr_up    <= 1'b0;
      rider_off <= 1'b1;
      vld       <= 1'b0;
    end else begin
      cur       <= nxt;
      pwr_up    <= nxt_act;
      rider_off <= !nxt_act;

      if (nxt != cur || !cond)
        db_cnt <= '0;
      else if (db_cnt != DB_LIM)
        db_cnt <= db_cnt + 24'd1;

      vld <= 1'b0;
      if (!nxt_act) begin
        smp_cnt <= '0;
      end else if (act && nxt_smpl) begin
        if (smp_cnt + 4'd1 == DECIM) begin
          smp_cnt <= '0;
          vld     <= 1'b1;
        end else begin
          smp_cnt <= smp_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_balance_seq.sv
// Randomized bench for balance_seq against a cycle-level behavioural model.
module tb_balance_seq;

  localparam int LIM = 256;
  localparam int DEC = 3;
  localparam int MIN = 512;
  localparam int LO  = 448;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_req;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        nxt_smpl;
  logic [7:0]  ss_tmr;
  logic        pwr_up;
  logic        rider_off;
  logic        vld;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_held, m_smp;
  bit m_vld;

  balance_seq #(
    .MIN_RIDER_WT(13'h0200),
    .WT_HYST(13'h0040),
    .DB_CYC(24'd256),
    .DECIM(4'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_req(en_req),
    .lft_ld(lft_ld),
    .rght_ld(rght_ld),
    .nxt_smpl(nxt_smpl),
    .ss_tmr(ss_tmr),
    .pwr_up(pwr_up),
    .rider_off(rider_off),
    .vld(vld),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit on(input int s);
    return s == 2 || s == 3;
  endfunction

  task automatic model_rst;
    m_st = 0; m_held = 0; m_smp = 0; m_vld = 0;
  endtask

  // One clock of the sequencer rules, using the inputs seen at the edge.
  task automatic model_step;
    int sum, prev, nx;
    bool_blk: begin
      sum  = int'(lft_ld) + int'(rght_ld);
      prev = m_st;
      nx   = prev;
      if (!en_req) begin
        nx = 0;
      end else if (prev == 0) begin
        nx = 1;
      end else if (prev == 1) begin
        if (sum >= MIN) begin
          m_held++;
          if (m_held >= LIM) nx = 2;
        end else m_held = 0;
      end else if (on(prev)) begin
        if (sum < LO) m_held++;
        else m_held = 0;
        if (m_held >= LIM) nx = 4;
        else if (prev == 2 && ss_tmr == 8'hFF) nx = 3;
      end else if (prev == 4) begin
        nx = 1;
      end else nx = 0;
    end
    if (nx != prev) m_held = 0;
    m_vld = 0;
    if (!on(nx)) m_smp = 0;
    else if (on(prev) && nxt_smpl) begin
      m_smp++;
      if (m_smp == DEC) begin
        m_smp = 0;
        m_vld = 1;
      end
    end
    m_st = nx;
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(state), m_st);
    chk("pwr_up", 32'(pwr_up), on(m_st) ? 1 : 0);
    chk("rider_off", 32'(rider_off), on(m_st) ? 0 : 1);
    chk("vld", 32'(vld), m_vld ? 1 : 0);
  endtask

  // Mid-cycle reset: outputs must clear without any clock edge.
  task automatic do_rst;
    #1 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_pwr", 32'(pwr_up), 0);
    chk("arst_roff", 32'(rider_off), 1);
    chk("arst_vld", 32'(vld), 0);
    model_rst();
    #1 rst = 1'b0;
  endtask

  task automatic set_ld(input int l, input int r);
    lft_ld  = 12'(l);
    rght_ld = 12'(r);
  endtask

  initial begin
    int npulse, s, len, b;
    rst = 1'b1; en_req = 1'b0; nxt_smpl = 1'b0; ss_tmr = '0;
    set_ld(0, 0);
    model_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_pwr", 32'(pwr_up), 0);
    chk("rst_roff", 32'(rider_off), 1);
    chk("rst_vld", 32'(vld), 0);
    rst = 1'b0;

    en_req = 1'b1;
    tick();
    chk("en_wait", 32'(state), 1);
    chk("en_roff", 32'(rider_off), 1);

    set_ld(12'h100, 12'h100);
    repeat (255) tick();
    set_ld(0, 0);
    tick();
    chk("db_255", 32'(state), 1);

    set_ld(12'h100, 12'h100);
    repeat (256) tick();
    chk("accept", 32'(state), 2);
    chk("accept_pwr", 32'(pwr_up), 1);
    chk("accept_roff", 32'(rider_off), 0);

    ss_tmr = 8'hFF;
    tick();
    chk("ss_run", 32'(state), 3);
    ss_tmr = 8'h00;

    set_ld(12'h0E0, 12'h0E0);
    repeat (1000) tick();
    chk("band", 32'(state), 3);

    set_ld(12'h100, 12'h100);
    npulse = 0;
    for (int i = 0; i < 9; i++) begin
      nxt_smpl = 1'b1;
      tick();
      nxt_smpl = 1'b0;
      chk("dec_strobe", 32'(vld), (i % 3 == 2) ? 1 : 0);
      if (vld) npulse++;
      tick();
      chk("dec_gap", 32'(vld), 0);
      if (vld) npulse++;
    end
    chk("dec_count", 32'(npulse), 3);

    set_ld(0, 0);
    repeat (255) tick();
    chk("loss_255", 32'(state), 3);
    tick();
    chk("halt", 32'(state), 4);
    tick();
    chk("halt_wait", 32'(state), 1);
    chk("halt_roff", 32'(rider_off), 1);

    set_ld(12'hFFF, 12'hFFF);
    repeat (256) tick();
    chk("max_ld", 32'(state), 2);
    ss_tmr = 8'hFF;
    tick();
    ss_tmr = 8'h00;
    repeat (2) begin
      nxt_smpl = 1'b1;
      tick();
    end
    en_req = 1'b0;
    tick();
    chk("ovr_state", 32'(state), 0);
    chk("ovr_vld", 32'(vld), 0);
    chk("ovr_pwr", 32'(pwr_up), 0);
    nxt_smpl = 1'b0;
    en_req = 1'b1;
    repeat (3) tick();
    do_rst();
    tick();
    chk("post_rst", 32'(state), 1);

    for (int seg = 0; seg < 60; seg++) begin
      b = $urandom_range(0, 4);
      if (b <= 1) begin
        set_ld($urandom_range(256, 4095), $urandom_range(256, 4095));
      end else if (b == 2) begin
        s = $urandom_range(448, 511);
        len = $urandom_range(0, s);
        set_ld(len, s - len);
      end else begin
        s = $urandom_range(0, 447);
        len = $urandom_range(0, s);
        set_ld(len, s - len);
      end
      len = $urandom_range(1, 400);
      for (int c = 0; c < len; c++) begin
        nxt_smpl = ($urandom % 3) == 0;
        ss_tmr = ($urandom % 50 == 0) ? 8'hFF : 8'($urandom % 255);
        en_req = ($urandom % 300) != 0;
        tick();
        if ($urandom % 1500 == 0) do_rst();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/balance_seq.md
BALANCE_SEQ -- requirements
Module: balance_seq

Interface
REQ-001 Parameter MIN_RIDER_WT, default 13'h0200: combined load at or above which a rider is present.
REQ-002 Parameter WT_HYST, default 13'h0040: hysteresis; rider is absent below MIN_RIDER_WT-WT_HYST.
REQ-003 Parameter DB_CYC, default 24'd5_000_000: consecutive cycles required to accept a rider-present or rider-absent decision.
REQ-004 Parameter DECIM, default 4'd1: number of sensor samples per vld pulse; legal range 1..15.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en_req  input  1  level; operator power enable.
REQ-008 lft_ld  input  12  unsigned left load-cell reading.
REQ-009 rght_ld  input  12  unsigned right load-cell reading.
REQ-010 nxt_smpl  input  1  one-cycle strobe; new inertial sample available.
REQ-011 ss_tmr  input  8  soft-start timer from the PID block.
REQ-012 pwr_up  output  1  enables PID soft-start timer and motors.
REQ-013 rider_off  output  1  clears PID integrator.
REQ-014 vld  output  1  one-cycle pulse; PID integrator update enable.
REQ-015 state  output  3  current FSM state code.

Function
REQ-016 Load sum SHALL be lft_ld+rght_ld computed zero-extended to 13 bits, with no overflow loss.
REQ-017 FSM states and codes SHALL be IDLE=0, WAIT_RIDER=1, SOFT_START=2, RUN=3, HALT=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-018 en_req=0 SHALL force IDLE on the next cycle from any state; this has highest priority.
REQ-019 IDLE -> WAIT_RIDER when en_req=1.
REQ-020 WAIT_RIDER -> SOFT_START when sum>=MIN_RIDER_WT holds for DB_CYC consecutive cycles.
REQ-021 SOFT_START -> RUN on the first cycle with ss_tmr==8'hFF.
REQ-022 SOFT_START or RUN -> HALT when sum<MIN_RIDER_WT-WT_HYST holds for DB_CYC consecutive cycles.
REQ-023 HALT SHALL last exactly one cycle and then go to WAIT_RIDER.
REQ-024 Debounce counter:
- counts cycles in which the state's target condition is true;
- clears when the condition is false, on any state change, and on reset;
- saturates at DB_CYC.
REQ-025 Sums between the two thresholds SHALL clear the debounce counter in every state.
REQ-026 Outputs SHALL be registered Moore outputs:
- pwr_up=1 only in SOFT_START and RUN;
- rider_off=0 only in SOFT_START and RUN.
REQ-027 Sample counter:
- 4-bit counter increments on nxt_smpl only in SOFT_START and RUN;
- vld=1 the cycle after the nxt_smpl that brings the count to DECIM;
- the counter wraps to 0 on that sample.
REQ-028 The sample counter SHALL clear whenever the state is not SOFT_START or RUN.
REQ-029 nxt_smpl arriving in the same cycle as a transition to HALT or IDLE SHALL NOT produce vld.

Reset
REQ-030 rst=1 SHALL asynchronously set: state=IDLE, pwr_up=0, rider_off=1, vld=0, debounce counter=0, sample counter=0.
REQ-031 Assertion of rst mid-operation SHALL take effect immediately, regardless of clk.
REQ-032 After rst deasserts, the first transition SHALL occur on the first rising edge of clk.

Configuration
REQ-033 Macro FAST_SIM_EN:
- when defined, the effective debounce limit SHALL be 256 cycles, regardless of DB_CYC;
- when undefined, the limit SHALL be DB_CYC;
- all other behaviour SHALL be identical in both cases.

Verification
REQ-034 Reset and enable: rst pulse, then en_req=1 -> state=1, pwr_up=0, rider_off=1.
REQ-035 Rider acceptance (FAST_SIM_EN, lft=rght=12'h100):
- sum held 256 cycles -> state=2, pwr_up=1, rider_off=0;
- sum held 255 cycles, then one cycle of lft=rght=0 -> state stays 1.
REQ-036 Soft start: in SOFT_START, drive ss_tmr=8'hFF -> state=3 on the next cycle.
REQ-037 Rider loss (in RUN):
- sum=13'h01C0 held for 1000 cycles -> stays in RUN (inside hysteresis band);
- sum=0 held 256 cycles -> HALT for one cycle, then WAIT_RIDER with rider_off=1.
REQ-038 Decimation: DECIM=3, 9 nxt_smpl strobes in RUN -> exactly 3 vld pulses, each one cycle after the 3rd, 6th and 9th strobe.
REQ-039 Override: en_req=0 during RUN with simultaneous nxt_smpl -> next cycle state=0, vld=0, pwr_up=0.
